// File: rtl/fp32_arith_unit.sv
// Single-cycle IEEE-754 binary32 add/sub/mul/div with four rounding modes and a registered output.
// Denormal operands are flushed to signed zero; results below the normal range flush to signed zero.
module fp32_arith_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  input  logic [2:0]            fpu_op,
  input  logic [1:0]            rmode,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  inf,
  output logic                  snan,
  output logic                  qnan,
  output logic                  ine,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  zero,
  output logic                  div_by_zero
);

  localparam logic [2:0]  OP_ADD = 3'b000;
  localparam logic [2:0]  OP_SUB = 3'b001;
  localparam logic [2:0]  OP_MUL = 3'b010;
  localparam logic [2:0]  OP_DIV = 3'b011;
  localparam logic [1:0]  RM_RNE = 2'b00;
  localparam logic [1:0]  RM_RTZ = 2'b01;
  localparam logic [1:0]  RM_RUP = 2'b10;
  localparam logic [1:0]  RM_RDN = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [23:0] ma, mb;

  assign {sa, ea, fa} = opa;
  assign {sb, eb, fb} = opb;
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_snan = a_nan && !fa[22];
  assign b_snan = b_nan && !fb[22];
  assign ma     = a_zero ? 24'd0 : {1'b1, fa};
  assign mb     = b_zero ? 24'd0 : {1'b1, fb};

  // Mantissas carry three extra bits (guard, round, sticky); bit 26 is the hidden one.
  logic               sb_eff, eff_sub, swap, s_big, align_sticky, sum_zero;
  logic [7:0]         e_big, e_small, e_diff;
  logic [23:0]        m_big, m_small;
  logic [4:0]         shamt, lz;
  logic [26:0]        x_al, y_full, y_al, add_mant;
  logic [27:0]        sum;
  logic signed [10:0] add_exp;

  always_comb begin
    sb_eff       = sb ^ (fpu_op == OP_SUB);
    eff_sub      = sa ^ sb_eff;
    swap         = {eb, mb} > {ea, ma};
    s_big        = swap ? sb_eff : sa;
    e_big        = swap ? eb : ea;
    e_small      = swap ? ea : eb;
    m_big        = swap ? mb : ma;
    m_small      = swap ? ma : mb;
    e_diff       = e_big - e_small;
    shamt        = (e_diff > 8'd27) ? 5'd27 : e_diff[4:0];
    x_al         = {m_big, 3'b000};
    y_full       = {m_small, 3'b000};
    align_sticky = |({1'b0, y_full} & ((28'd1 << shamt) - 28'd1));
    y_al         = (y_full >> shamt) | {26'd0, align_sticky};
    sum          = eff_sub ? ({1'b0, x_al} - {1'b0, y_al}) : ({1'b0, x_al} + {1'b0, y_al});
    sum_zero     = (sum == 28'd0);
    lz           = lzc27(sum[26:0]);
    if (sum[27]) begin
      add_mant = {sum[27:2], sum[1] | sum[0]};
      add_exp  = $signed({3'b000, e_big}) + 11'sd1;
    end else begin
      add_mant = sum[26:0] << lz;
      add_exp  = $signed({3'b000, e_big}) - $signed({6'd0, lz});
    end
  end

  logic [47:0]        prod;
  logic [26:0]        mul_mant;
  logic signed [10:0] mul_exp;

  assign prod     = {24'd0, ma} * {24'd0, mb};
  assign mul_mant = prod[47] ? {prod[47:22], |prod[21:0]} : {prod[46:21], |prod[20:0]};
  assign mul_exp  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
                  + (prod[47] ? 11'sd1 : 11'sd0);

  // Quotient keeps 28 bits so both normalisations leave guard/round bits; remainder feeds sticky.
  logic [50:0]        dividend, divisor;
  logic [27:0]        quo;
  logic [23:0]        rem;
  logic               rem_nz;
  logic [26:0]        div_mant;
  logic signed [10:0] div_exp;

  assign dividend = {ma, 27'd0};
  assign divisor  = {27'd0, mb};
  assign quo      = 28'(dividend / divisor);
  assign rem      = 24'(dividend % divisor);
  assign rem_nz   = (rem != 24'd0);
  assign div_mant = quo[27] ? {quo[27:2], (|quo[1:0]) | rem_nz} : {quo[26:1], quo[0] | rem_nz};
  assign div_exp  = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd127
                  - (quo[27] ? 11'sd0 : 11'sd1);

  logic               r_sign;
  logic signed [10:0] r_exp;
  logic [26:0]        r_mant;

  always_comb begin
    r_sign = sa ^ sb;
    r_exp  = mul_exp;
    r_mant = mul_mant;
    case (fpu_op)
      OP_ADD, OP_SUB: begin
        r_sign = s_big;
        r_exp  = add_exp;
        r_mant = add_mant;
      end
      OP_DIV: begin
        r_exp  = div_exp;
        r_mant = div_mant;
      end
      default: ;
    endcase
  end

  logic               inexact, round_up, ovf, unf, to_inf;
  logic [24:0]        rounded;
  logic [22:0]        frac;
  logic signed [10:0] exp_rnd;

  always_comb begin
    inexact  = |r_mant[2:0];
    round_up = 1'b0;
    case (rmode)
      RM_RNE:  round_up = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
      RM_RTZ:  round_up = 1'b0;
      RM_RUP:  round_up = inexact & !r_sign;
      default: round_up = inexact & r_sign;
    endcase
    rounded = {1'b0, r_mant[26:3]} + {24'd0, round_up};
    exp_rnd = r_exp + (rounded[24] ? 11'sd1 : 11'sd0);
    frac    = rounded[24] ? rounded[23:1] : rounded[22:0];
    ovf     = (exp_rnd >= 11'sd255);
    unf     = (exp_rnd < 11'sd1);
    to_inf  = (rmode == RM_RNE) || (rmode == RM_RUP && !r_sign) || (rmode == RM_RDN && r_sign);
  end

  // Special-operand outcomes per opcode; they take priority over the rounded finite result.
  logic invalid, sp_inf, sp_zero, inf_sign, zero_sign, dbz;

  always_comb begin
    invalid   = 1'b0;
    sp_inf    = 1'b0;
    sp_zero   = 1'b0;
    inf_sign  = sa ^ sb;
    zero_sign = sa ^ sb;
    dbz       = 1'b0;
    case (fpu_op)
      OP_ADD, OP_SUB: begin
        invalid   = a_inf & b_inf & eff_sub;
        sp_inf    = a_inf | b_inf;
        inf_sign  = a_inf ? sa : sb_eff;
        sp_zero   = sum_zero;
        zero_sign = eff_sub ? (rmode == RM_RDN) : sa;
      end
      OP_MUL: begin
        invalid = (a_inf & b_zero) | (a_zero & b_inf);
        sp_inf  = a_inf | b_inf;
        sp_zero = a_zero | b_zero;
      end
      OP_DIV: begin
        invalid = (a_zero & b_zero) | (a_inf & b_inf);
        sp_inf  = a_inf | b_zero;
        dbz     = b_zero & !a_inf;
        sp_zero = a_zero | b_inf;
      end
      default: ;
    endcase
  end

  logic [31:0] res;
  logic        f_inf, f_snan, f_qnan, f_ine, f_ovf, f_unf, f_zero, f_dbz;

  always_comb begin
    res    = 32'd0;
    f_inf  = 1'b0;
    f_snan = 1'b0;
    f_qnan = 1'b0;
    f_ine  = 1'b0;
    f_ovf  = 1'b0;
    f_unf  = 1'b0;
    f_zero = 1'b0;
    f_dbz  = 1'b0;
    if (fpu_op[2]) begin
      res = 32'd0;
    end else if (a_nan || b_nan || invalid) begin
      res    = QNAN;
      f_qnan = 1'b1;
      f_snan = a_snan | b_snan;
    end else if (sp_inf) begin
      res   = {inf_sign, 8'hFF, 23'd0};
      f_inf = 1'b1;
      f_dbz = dbz;
    end else if (sp_zero) begin
      res    = {zero_sign, 31'd0};
      f_zero = 1'b1;
    end else if (ovf) begin
      res   = to_inf ? {r_sign, 8'hFF, 23'd0} : {r_sign, 8'hFE, 23'h7FFFFF};
      f_inf = to_inf;
      f_ovf = 1'b1;
      f_ine = 1'b1;
    end else if (unf) begin
      res    = {r_sign, 31'd0};
      f_unf  = 1'b1;
      f_ine  = 1'b1;
      f_zero = 1'b1;
    end else begin
      res   = {r_sign, exp_rnd[7:0], frac};
      f_ine = inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out         <= '0;
      inf         <= 1'b0;
      snan        <= 1'b0;
      qnan        <= 1'b0;
      ine         <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out         <= res;
      inf         <= f_inf;
      snan        <= f_snan;
      qnan        <= f_qnan;
      ine         <= f_ine;
      overflow    <= f_ovf;
      underflow   <= f_unf;
      zero        <= f_zero;
      div_by_zero <= f_dbz;
    end
  end

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Directed bench for fp32_arith_unit: hand-computed vector table plus reset and back-to-back sequences.
// Flag byte order is {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}.
module tb_fp32_arith_unit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_RSV = 3'b100;
  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  localparam logic [7:0] F_INF = 8'h80;
  localparam logic [7:0] F_SNAN = 8'h40;
  localparam logic [7:0] F_QNAN = 8'h20;
  localparam logic [7:0] F_INE = 8'h10;
  localparam logic [7:0] F_OVF = 8'h08;
  localparam logic [7:0] F_UNF = 8'h04;
  localparam logic [7:0] F_ZERO = 8'h02;
  localparam logic [7:0] F_DBZ = 8'h01;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [7:0]  flags;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] opa, opb, out;
  logic [2:0]  fpu_op;
  logic [1:0]  rmode;
  logic        inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero;
  logic [7:0]  flags_act;

  int num_checks = 0;
  int num_fails = 0;
  vec_t vecs[$];

  fp32_arith_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opa(opa), .opb(opb), .fpu_op(fpu_op), .rmode(rmode),
    .out(out), .inf(inf), .snan(snan), .qnan(qnan), .ine(ine), .overflow(overflow),
    .underflow(underflow), .zero(zero), .div_by_zero(div_by_zero)
  );

  assign flags_act = {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive a new operation half a cycle before the sampling edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rm,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    fpu_op = op;
    rmode  = rm;
    opa    = a;
    opb    = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitSample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{OP_ADD, RNE, 32'h3F800000, 32'h40000000, 32'h40400000, 8'h00});
    vecs.push_back('{OP_MUL, RNE, 32'h3FC00000, 32'h40000000, 32'h40400000, 8'h00});
    vecs.push_back('{OP_SUB, RNE, 32'h3F800000, 32'h3F800000, 32'h00000000, F_ZERO});
    vecs.push_back('{OP_DIV, RNE, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_INE});
    vecs.push_back('{OP_DIV, RTZ, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_INE});
    vecs.push_back('{OP_DIV, RUP, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_INE});
    vecs.push_back('{OP_DIV, RDN, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_INE});
    vecs.push_back('{OP_DIV, RNE, 32'h3F800000, 32'h00000000, 32'h7F800000, F_INF | F_DBZ});
    vecs.push_back('{OP_MUL, RNE, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, F_INF | F_INE | F_OVF});
    vecs.push_back('{OP_MUL, RTZ, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, F_INE | F_OVF});
    vecs.push_back('{OP_MUL, RUP, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, F_INF | F_INE | F_OVF});
    vecs.push_back('{OP_MUL, RDN, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, F_INE | F_OVF});
    vecs.push_back('{OP_MUL, RUP, 32'hFF7FFFFF, 32'h40000000, 32'hFF7FFFFF, F_INE | F_OVF});
    vecs.push_back('{OP_ADD, RNE, 32'h7F800001, 32'h3F800000, 32'h7FC00000, F_SNAN | F_QNAN});
    vecs.push_back('{OP_ADD, RNE, 32'h7F800000, 32'hFF800000, 32'h7FC00000, F_QNAN});
    vecs.push_back('{OP_MUL, RNE, 32'h00800000, 32'h00800000, 32'h00000000, F_UNF | F_INE | F_ZERO});
    vecs.push_back('{OP_SUB, RDN, 32'h3F800000, 32'h3F800000, 32'h80000000, F_ZERO});
    vecs.push_back('{OP_ADD, RNE, 32'h80000000, 32'h80000000, 32'h80000000, F_ZERO});
    vecs.push_back('{OP_RSV, RNE, 32'h3F800000, 32'h40000000, 32'h00000000, 8'h00});
    vecs.push_back('{OP_MUL, RNE, 32'h00000000, 32'h7F800000, 32'h7FC00000, F_QNAN});
    vecs.push_back('{OP_ADD, RNE, 32'h00000001, 32'h3F800000, 32'h3F800000, 8'h00});
    vecs.push_back('{OP_MUL, RNE, 32'hC0000000, 32'h40400000, 32'hC0C00000, 8'h00});
    vecs.push_back('{OP_ADD, RNE, 32'h3F800000, 32'h33800000, 32'h3F800000, F_INE});
    vecs.push_back('{OP_ADD, RUP, 32'h3F800000, 32'h33800000, 32'h3F800001, F_INE});
    vecs.push_back('{OP_ADD, RNE, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, F_INE});
    vecs.push_back('{OP_SUB, RNE, 32'h3F800000, 32'h3F800001, 32'hB4000000, 8'h00});
    vecs.push_back('{OP_DIV, RNE, 32'h40C00000, 32'hC0000000, 32'hC0400000, 8'h00});
    vecs.push_back('{OP_SUB, RNE, 32'h7F800000, 32'h3F800000, 32'h7F800000, F_INF});
    vecs.push_back('{OP_DIV, RNE, 32'h7F800000, 32'h7F800000, 32'h7FC00000, F_QNAN});
    vecs.push_back('{OP_MUL, RNE, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, F_QNAN});

    // Reset held low for two edges while a valid add is presented.
    reset  = 1'b0;
    fpu_op = OP_ADD;
    rmode  = RNE;
    opa    = 32'h3F800000;
    opb    = 32'h40000000;
    for (int i = 0; i < 2; i++) begin
      waitSample();
      checkOutput("reset_out", out, 32'h0);
      checkOutput("reset_flags", {24'd0, flags_act}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(OP_ADD, RNE, 32'h3F800000, 32'h40000000);
    waitSample();
    checkOutput("first_add_out", out, 32'h40400000);
    checkOutput("first_add_flags", {24'd0, flags_act}, 32'h0);

    // Back-to-back issue: result lands one edge after its inputs and holds until the next edge.
    applyStimulus(OP_MUL, RNE, 32'h3FC00000, 32'h40000000);
    waitSample();
    checkOutput("b2b_mul_out", out, 32'h40400000);
    applyStimulus(OP_SUB, RNE, 32'h3F800000, 32'h3F800000);
    checkOutput("b2b_hold_out", out, 32'h40400000);
    checkOutput("b2b_hold_flags", {24'd0, flags_act}, 32'h0);
    waitSample();
    checkOutput("b2b_sub_out", out, 32'h00000000);
    checkOutput("b2b_sub_flags", {24'd0, flags_act}, {24'd0, F_ZERO});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].rm, vecs[i].a, vecs[i].b);
      waitSample();
      checkOutput($sformatf("vec%0d_out", i), out, vecs[i].res);
      checkOutput($sformatf("vec%0d_flags", i), {24'd0, flags_act}, {24'd0, vecs[i].flags});
    end

    // Mid-stream reset discards the operation presented at the reset edge.
    applyStimulus(OP_DIV, RNE, 32'h3F800000, 32'h00000000);
    waitSample();
    checkOutput("pre_midreset_out", out, 32'h7F800000);
    applyStimulus(OP_MUL, RNE, 32'h7F7FFFFF, 32'h40000000);
    reset = 1'b0;
    waitSample();
    checkOutput("midreset_out", out, 32'h0);
    checkOutput("midreset_flags", {24'd0, flags_act}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(OP_DIV, RTZ, 32'h3F800000, 32'h40400000);
    waitSample();
    checkOutput("post_midreset_out", out, 32'h3EAAAAAA);
    checkOutput("post_midreset_flags", {24'd0, flags_act}, {24'd0, F_INE});

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
